// File: rtl/x2_bist_driver.sv
// Self-test driver for x2: LFSR stimulus generator plus 7-bit MISR response compactor.
// One vector per cycle in RUN; done rises N+1 edges after start is sampled; start is ignored mid-run.
module x2_bist_driver #(
    parameter int unsigned     NUM_VECTORS = 1023,
    parameter logic [9:0]      LFSR_SEED   = 10'h001,
    parameter logic [6:0]      MISR_SEED   = 7'h00
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        start,
    output logic [9:0]  vec_o,
    input  logic [6:0]  rsp_i,
    output logic        busy,
    output logic        done,
    output logic [6:0]  signature,
    output logic [9:0]  count
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam logic [9:0] LAST_COUNT = 10'(NUM_VECTORS);

    state_t     state_q;
    logic [9:0] vec_q;
    logic [6:0] misr_q;
    logic [9:0] count_q;
    logic       busy_q;
    logic       done_q;

    logic [9:0] vec_d;
    logic [6:0] misr_d;
    logic [9:0] count_d;

    // vec_q doubles as the LFSR state; it is only meaningful while in RUN.
    assign vec_d   = {vec_q[8:0], vec_q[9] ^ vec_q[6]};
    assign misr_d  = {misr_q[5:0], misr_q[6] ^ misr_q[5]} ^ rsp_i;
    assign count_d = count_q + 10'd1;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            vec_q   <= '0;
            misr_q  <= '0;
            count_q <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            case (state_q)
                IDLE, DONE: begin
                    if (start) begin
                        state_q <= RUN;
                        vec_q   <= LFSR_SEED;
                        misr_q  <= MISR_SEED;
                        count_q <= '0;
                        busy_q  <= 1'b1;
                        done_q  <= 1'b0;
                    end
                end
                RUN: begin
                    misr_q  <= misr_d;
                    count_q <= count_d;
                    // The final edge still compacts its response but drops the stimulus.
                    if (count_d == LAST_COUNT) begin
                        state_q <= DONE;
                        vec_q   <= '0;
                        busy_q  <= 1'b0;
                        done_q  <= 1'b1;
                    end else begin
                        vec_q   <= vec_d;
                    end
                end
                default: begin
                    state_q <= IDLE;
                    vec_q   <= '0;
                    busy_q  <= 1'b0;
                    done_q  <= 1'b0;
                end
            endcase
        end
    end

    assign vec_o     = vec_q;
    assign busy      = busy_q;
    assign done      = done_q;
    assign signature = misr_q;
    assign count     = count_q;

endmodule

// File: doc/x2_bist_driver.md
# x2_bist_driver

Self-test driver for the x2 combinational control block. It generates x2's 10-bit input vector (pa..pj) from an LFSR and compacts x2's 7-bit response (pk..pq) into a MISR signature. A run lasts a programmable number of vectors; after the run the block reports done, the signature and the vector count to the test controller.

## Interface

- `NUM_VECTORS`, default 1023: vectors applied per run; legal range 1..1023.
- `LFSR_SEED`, default 10'h001: first vector of a run; must be non-zero.
- `MISR_SEED`, default 7'h00: signature register value at the start of a run.

Ports:

- `clk`  in  1  the single clock; all state changes on the rising edge.
- `rst_n`  in  1  reset, asynchronous and active-low.
- `start`  in  1  level-sampled run request.
- `vec_o`  out  10  drives the x2 inputs: bit9=pa, bit8=pb … bit0=pj.
- `rsp_i`  in  7  x2 outputs: bit0=pk, bit1=pl, bit2=pm, bit3=pn, bit4=po, bit5=pp, bit6=pq.
- `busy`  out  1  high while in RUN.
- `done`  out  1  high while in DONE.
- `signature`  out  7  MISR contents; final value is valid while done=1.
- `count`  out  10  number of vectors compacted in the current or last run.

## Operation

- The FSM has three states: IDLE, RUN and DONE. `vec_o`, `signature` and `count` are registered.
- **IDLE**
  - `vec_o`=0 and `busy`=`done`=0.
  - If `start`=1, the next edge loads lfsr=`LFSR_SEED`, misr=`MISR_SEED` and count=0, and moves to RUN.
- **RUN**
  - `busy`=1. `vec_o` holds the current LFSR value.
  - Each edge does all of the following:
    - misr ← {misr[5:0], misr[6]^misr[5]} ^ `rsp_i`
    - lfsr ← {lfsr[8:0], lfsr[9]^lfsr[6]}, the polynomial x^10+x^7+1, maximal length 1023
    - count ← count+1
  - On the edge where count transitions to `NUM_VECTORS`, the FSM moves to DONE. That edge still performs its MISR update, and `vec_o` is cleared to 0.
  - `start` is ignored in RUN.
- **DONE**
  - `done`=1, `busy`=0 and `vec_o`=0. `signature` and `count` hold.
  - If `start`=1, the next edge reloads the seeds, clears count and re-enters RUN.
  - If `start`=0, the FSM stays in DONE. There is no automatic return to IDLE.
- **Arithmetic:** count is a 10-bit unsigned counter and never exceeds `NUM_VECTORS`. The LFSR never reaches 0 from a non-zero seed. With `NUM_VECTORS`=1023, every non-zero 10-bit vector is applied exactly once.

## Timing

- **Reset values:** state=IDLE, `vec_o`=0, `busy`=0, `done`=0, `signature`=0, `count`=0. Reset takes effect immediately and asynchronously from any state, including mid-RUN. In that case the partial signature is discarded.
- **Start to RUN:** `start` sampled high at edge E0 gives `busy`=1 and `vec_o`=`LFSR_SEED` after E0.
- **Response sampling:** x2 is combinational, so `rsp_i` is sampled in the same cycle the corresponding `vec_o` is driven. The response to vector k is compacted at edge E0+k, for k=1..N.
- **Completion:** `done` rises after edge E0+N and `busy` falls at the same edge. Start-to-done latency is N+1 edges counted from E0, inclusive.
- **`start` held high:** in DONE, a continuously high `start` gives back-to-back runs. DONE lasts exactly one cycle between runs.
- **Simultaneous events:** reset asserted together with `start` wins.

## Test plan

- **Reset:** assert `rst_n`=0 mid-RUN (cycle 5 of a 1023-vector run) → `vec_o`, `busy`, `done`, `signature` and `count` are all 0 immediately. After release the FSM is in IDLE and ignores nothing.
- **LFSR sequence:** default seed, `start` pulse → `vec_o` goes 001, 002, 004, 008, 010, 020, 040, 081, 102 on consecutive cycles.
- **MISR arithmetic:** `NUM_VECTORS`=3, `MISR_SEED`=0, `rsp_i` held at 7'h01 → `signature` goes 01, 03, 07. The final value is 7'h07, with `done`=1, `count`=3, and `done` rising 4 edges after `start` is sampled.
- **Full run:** `NUM_VECTORS`=1023 with a scoreboard → `vec_o` is never 0, no vector repeats, `count`=1023, and the LFSR would return to 001 on the next step. `signature` equals the software MISR model computed over a golden x2 model.
- **Minimum run:** `NUM_VECTORS`=1, `rsp_i`=7'h55 → `busy` is high for exactly 1 cycle, `signature`=7'h55 and `count`=1.
- **Restart and ignored start:** `start` held high through two runs → DONE lasts 1 cycle and the second run produces an identical signature. A `start` pulse during RUN has no effect on `count` or `signature`.
